// File: rtl/a2d_load_intf_if.sv
// Bundle for the A2D load interface: SPI pins to the ADC128S, the conversion
// request, and the four registered readings with their update strobe.
`timescale 1ns/1ps
interface a2d_load_intf_if;
    logic        nxt;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_done;

    modport master (
        input  nxt, MISO,
        output SS_n, SCLK, MOSI, lft_ld, rght_ld, steer_pot, batt, cnv_done
    );

    modport slave (
        output nxt, MISO,
        input  SS_n, SCLK, MOSI, lft_ld, rght_ld, steer_pot, batt, cnv_done
    );
endinterface

// File: rtl/a2d_load_intf.sv
// Round-robin ADC128S reader: per nxt, two SPI frames (address, then read) for ch0/4/5/6.
// Latency nxt->cnv_done 1043 clk; nxt is only accepted in IDLE, never queued.
`timescale 1ns/1ps
module a2d_load_intf (
    input  logic          clk,
    input  logic          rst,
    a2d_load_intf_if.master bus
);
    localparam logic [4:0] SCLK_LOAD = 5'b10111;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

    state_t      state, nxt_state;
    logic        wrt, done;
    logic [15:0] cmd, shft;
    logic [4:0]  sclk_div, bit_cnt;
    logic        miso_smpl, ss_n_q;
    logic [1:0]  ch_idx;
    logic [2:0]  ch_code;

    // ---------------- SPI master ----------------
    // sclk_div rests at SCLK_LOAD and starts counting on the wrt edge itself,
    // so the first SCLK fall lands 8 clks after SS_n falls and a frame is 520 clks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_q    <= 1'b1;
            sclk_div  <= SCLK_LOAD;
            shft      <= 16'h0000;
            bit_cnt   <= 5'd0;
            miso_smpl <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wrt) begin
                shft     <= cmd;
                sclk_div <= SCLK_LOAD + 5'd1;
                bit_cnt  <= 5'd0;
                ss_n_q   <= 1'b0;
            end else if (!ss_n_q) begin
                sclk_div <= sclk_div + 5'd1;
                if (sclk_div == 5'b01111) begin
                    miso_smpl <= bus.MISO;
                    bit_cnt   <= bit_cnt + 5'd1;
                end
                // The leading fall (bit_cnt==0) precedes any sample and is not a shift
                if (sclk_div == 5'b11111 && bit_cnt != 5'd0) begin
                    shft <= {shft[14:0], miso_smpl};
                    if (bit_cnt == 5'd16) begin
                        ss_n_q   <= 1'b1;
                        done     <= 1'b1;
                        sclk_div <= SCLK_LOAD;
                    end
                end
            end
        end
    end

    assign bus.SS_n = ss_n_q;
    assign bus.SCLK = ss_n_q | sclk_div[4];
    assign bus.MOSI = shft[15];

    // ---------------- conversion sequencer ----------------
    always_comb begin
        ch_code = 3'd0;
        case (ch_idx)
            2'd0:    ch_code = 3'd0;
            2'd1:    ch_code = 3'd4;
            2'd2:    ch_code = 3'd5;
            default: ch_code = 3'd6;
        endcase
    end

    assign cmd = {2'b00, ch_code, 11'h000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    // State is already IDLE while cnv_done is high; a nxt in that clk belongs
    // to the finishing conversion and is dropped.
    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        case (state)
            IDLE: if (bus.nxt && !bus.cnv_done) begin
                wrt       = 1'b1;
                nxt_state = CMD;
            end
            CMD:  if (done) nxt_state = GAP;
            GAP: begin
                wrt       = 1'b1;
                nxt_state = READ;
            end
            READ: if (done) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx        <= 2'd0;
            bus.cnv_done  <= 1'b0;
            bus.lft_ld    <= 12'h000;
            bus.rght_ld   <= 12'h000;
            bus.steer_pot <= 12'h000;
            bus.batt      <= 12'h000;
        end else begin
            bus.cnv_done <= 1'b0;
            if (state == READ && done) begin
                bus.cnv_done <= 1'b1;
                ch_idx       <= ch_idx + 2'd1;
                case (ch_idx)
                    2'd0:    bus.lft_ld    <= shft[11:0];
                    2'd1:    bus.rght_ld   <= shft[11:0];
                    2'd2:    bus.steer_pot <= shft[11:0];
                    default: bus.batt      <= shft[11:0];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_a2d_load_intf.sv
// Directed bench for a2d_load_intf with a behavioural ADC128S on the SPI pins.
`timescale 1ns/1ps
module tb_a2d_load_intf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    a2d_load_intf_if bus ();
    a2d_load_intf dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    // ADC model state and frame monitor
    logic [11:0] adc_val [8];
    logic [2:0]  last_ch = 3'd0;
    logic [15:0] resp, cmd_sh;
    logic [15:0] cmd_q [$];
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, in_frame = 1'b0;
    int          cyc = 0, low_cnt = 0, rises = 0, last_rise = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
            in_frame = 1'b0; bus.MISO = 1'b0;
        end else begin
            if (prev_ss && !bus.SS_n) begin
                in_frame = 1'b1; low_cnt = 0; rises = 0; cmd_sh = 16'h0;
                resp = {4'h0, adc_val[last_ch]};
                bus.MISO = resp[15];
            end
            if (!bus.SS_n) low_cnt++;
            if (!bus.SS_n && !prev_sclk && bus.SCLK) begin
                rises++;
                cmd_sh = {cmd_sh[14:0], bus.MOSI};
                checks++;
                if (bus.MOSI !== prev_mosi) begin
                    errors++;
                    $display("FAIL mosi_stable rise %0d: after=%b before=%b", rises, bus.MOSI, prev_mosi);
                end
                if (rises > 1) begin
                    checks++;
                    if (cyc - last_rise != 32) begin
                        errors++;
                        $display("FAIL sclk_period: got %0d clks, want 32", cyc - last_rise);
                    end
                end
                last_rise = cyc;
            end
            if (!bus.SS_n && prev_sclk && !bus.SCLK && rises > 0 && rises < 16)
                bus.MISO = resp[15 - rises];
            if (!prev_ss && bus.SS_n && in_frame) begin
                checks += 2;
                if (low_cnt != 520) begin
                    errors++;
                    $display("FAIL ss_low_len: got %0d, want 520", low_cnt);
                end
                if (rises != 16) begin
                    errors++;
                    $display("FAIL sclk_rises: got %0d, want 16", rises);
                end
                cmd_q.push_back(cmd_sh);
                last_ch  = cmd_sh[13:11];
                in_frame = 1'b0;
            end
            prev_ss = bus.SS_n; prev_sclk = bus.SCLK; prev_mosi = bus.MOSI;
        end
    end

    function automatic void get_regs(output logic [11:0] r [4]);
        r[0] = bus.lft_ld; r[1] = bus.rght_ld; r[2] = bus.steer_pot; r[3] = bus.batt;
    endfunction

    logic [11:0] exp_reg [4];

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
    endtask

    task automatic pulse_nxt();
        @(negedge clk); bus.nxt = 1'b1;
        @(negedge clk); bus.nxt = 1'b0;
    endtask

    // Returns the number of clks from the nxt-sampling edge to the cnv_done clk
    task automatic wait_cnv(input string name, output int lat);
        lat = 0;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (bus.cnv_done) begin lat = n; break; end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL %s_timeout: no cnv_done within 1200 clks", name);
        end
    endtask

    task automatic test_reset();
        logic [11:0] r [4];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        get_regs(r);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r[i] !== 12'h000) begin
                errors++; $display("FAIL reset_reg%0d: got %h want 000", i, r[i]);
            end
        end
        checks += 4;
        if (bus.SS_n !== 1'b1)     begin errors++; $display("FAIL reset_ss_n: got %b want 1", bus.SS_n); end
        if (bus.SCLK !== 1'b1)     begin errors++; $display("FAIL reset_sclk: got %b want 1", bus.SCLK); end
        if (bus.MOSI !== 1'b0)     begin errors++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
        if (bus.cnv_done !== 1'b0) begin errors++; $display("FAIL reset_cnv_done: got %b want 0", bus.cnv_done); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
    endtask

    task automatic test_single();
        logic [11:0] r [4];
        int lat;
        adc_val[0] = 12'hA5C;
        cmd_q.delete();
        pulse_nxt();
        wait_cnv("single", lat);
        get_regs(r);
        checks += 6;
        if (lat != 1043) begin errors++; $display("FAIL single_latency: got %0d want 1043", lat); end
        if (r[0] !== 12'hA5C) begin errors++; $display("FAIL single_lft: got %h want a5c", r[0]); end
        if (r[1] !== 12'h0 || r[2] !== 12'h0 || r[3] !== 12'h0) begin
            errors++; $display("FAIL single_others: got %h %h %h want 000", r[1], r[2], r[3]);
        end
        if (cmd_q.size() != 2) begin errors++; $display("FAIL single_frames: got %0d want 2", cmd_q.size()); end
        else if (cmd_q[0] !== 16'h0000 || cmd_q[1] !== 16'h0000) begin
            errors++; $display("FAIL single_cmd: got %h %h want 0000 0000", cmd_q[0], cmd_q[1]);
        end
        else checks--;
        @(negedge clk);
        if (bus.cnv_done !== 1'b0) begin errors++; $display("FAIL single_pulse_width: cnv_done still %b", bus.cnv_done); end
        if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL single_idle_ss: got %b want 1", bus.SS_n); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_cmd [5];
        logic [11:0] val [5];
        int          slot [5];
        logic [11:0] r [4];
        int lat;
        exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000};
        val     = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h777};
        slot    = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            adc_val[exp_cmd[k][13:11]] = val[k];
            cmd_q.delete();
            pulse_nxt();
            wait_cnv("rr", lat);
            exp_reg[slot[k]] = val[k];
            get_regs(r);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (r[i] !== exp_reg[i]) begin
                    errors++; $display("FAIL rr%0d_reg%0d: got %h want %h", k, i, r[i], exp_reg[i]);
                end
            end
            checks++;
            if (cmd_q.size() != 2 || cmd_q[0] !== exp_cmd[k] || cmd_q[1] !== exp_cmd[k]) begin
                errors++; $display("FAIL rr%0d_cmd: frames=%0d first=%h want 2x %h", k, cmd_q.size(),
                                   (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx, exp_cmd[k]);
            end
        end
    endtask

    // Pointer is at ch4 here; repeated nxt while busy must not start more frames
    task automatic test_nxt_ignored();
        int n;
        cmd_q.delete();
        adc_val[4] = 12'h5A5;
        pulse_nxt();
        n = 0;
        for (int t = 0; t < 1200; t++) begin
            @(negedge clk); n++;
            if (bus.cnv_done) break;
            bus.nxt = (n % 100 == 50);
        end
        checks++;
        if (!bus.cnv_done) begin errors++; $display("FAIL ign_timeout: no cnv_done"); end
        bus.nxt = 1'b1;   // same clk as cnv_done: must be dropped
        @(negedge clk); bus.nxt = 1'b0;
        repeat (40) @(negedge clk);
        exp_reg[1] = 12'h5A5;
        checks += 3;
        if (cmd_q.size() != 2) begin errors++; $display("FAIL ign_frames: got %0d want 2", cmd_q.size()); end
        if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL ign_idle: SS_n=%b want 1", bus.SS_n); end
        if (bus.rght_ld !== 12'h5A5) begin errors++; $display("FAIL ign_rght: got %h want 5a5", bus.rght_ld); end
    endtask

    // nxt in the first clk after cnv_done is accepted and targets the next channel
    task automatic test_back_to_back();
        int lat;
        cmd_q.delete();
        adc_val[5] = 12'hBEE;
        adc_val[6] = 12'h0C3;
        pulse_nxt();
        wait_cnv("b2b_a", lat);
        @(negedge clk); bus.nxt = 1'b1;
        @(negedge clk); bus.nxt = 1'b0;
        wait_cnv("b2b_b", lat);
        checks += 4;
        if (lat != 1043) begin errors++; $display("FAIL b2b_latency: got %0d want 1043", lat); end
        if (bus.steer_pot !== 12'hBEE) begin errors++; $display("FAIL b2b_steer: got %h want bee", bus.steer_pot); end
        if (bus.batt !== 12'h0C3) begin errors++; $display("FAIL b2b_batt: got %h want 0c3", bus.batt); end
        if (cmd_q.size() != 4 || cmd_q[0] !== 16'h2800 || cmd_q[3] !== 16'h3000) begin
            errors++; $display("FAIL b2b_cmds: frames=%0d want 2800,2800,3000,3000", cmd_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] r [4];
        int lat;
        adc_val[0] = 12'h9F1;
        pulse_nxt();                 // ch0 conversion, pointer moves to ch4
        wait_cnv("mid_pre", lat);
        pulse_nxt();                 // ch4, interrupted in its READ frame
        repeat (700) @(negedge clk);
        checks++;
        if (bus.SS_n !== 1'b0) begin errors++; $display("FAIL mid_active: SS_n=%b want 0", bus.SS_n); end
        rst = 1'b1;
        #1;
        get_regs(r);
        checks += 3;
        if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL mid_ss_n: got %b want 1", bus.SS_n); end
        if (bus.SCLK !== 1'b1) begin errors++; $display("FAIL mid_sclk: got %b want 1", bus.SCLK); end
        if (r[0] !== 12'h0 || r[1] !== 12'h0 || r[2] !== 12'h0 || r[3] !== 12'h0) begin
            errors++; $display("FAIL mid_regs: got %h %h %h %h want 0", r[0], r[1], r[2], r[3]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmd_q.delete();
        adc_val[0] = 12'h3C7;
        pulse_nxt();
        wait_cnv("mid_post", lat);
        checks += 3;
        if (cmd_q.size() < 1 || cmd_q[0] !== 16'h0000) begin
            errors++; $display("FAIL mid_ptr: first cmd %h want 0000", (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx);
        end
        if (bus.lft_ld !== 12'h3C7) begin errors++; $display("FAIL mid_lft: got %h want 3c7", bus.lft_ld); end
        if (bus.rght_ld !== 12'h000) begin errors++; $display("FAIL mid_rght: got %h want 000", bus.rght_ld); end
    endtask

    initial begin
        bus.nxt = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        test_reset();
        test_single();
        test_round_robin();
        test_nxt_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
